sipo_deserializer: RTL
======================

# sipo_deserializer

Parametrised serial-in/parallel-out deserializer. It collects a qualified 1-bit serial stream into WIDTH-bit words and selects bit order at elaboration. Each completed word is presented on a double-buffered valid/ready output, so collection of the next word continues while the previous one waits. It is the next-generation replacement for the fixed 4-bit shift register and sits between serial receive front-ends and word-wide datapath consumers.

## Interface
- WIDTH, 8: word width in bits; legal range is 2 and up.
- MSB_FIRST, 1: bit order.
  - 1: the first received bit lands in q_data[WIDTH-1].
  - 0: the first received bit lands in q_data[0].
- clk  in  1: single clock; all state changes on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- clear  in  1: synchronous flush of the partial word and the holding register.
- sin_valid  in  1: qualifies sin; one bit is accepted per cycle while high.
- sin  in  1: serial data bit.
- q_data  out  WIDTH: completed word, from the holding register.
- q_valid  out  1: holding register is full.
- q_ready  in  1: consumer accepts the word when q_valid and q_ready are both high.
- q_perr  out  1: parity error flag for q_data; only meaningful with the parity option.
- overrun  out  1: one-cycle pulse; a completed word was dropped.
- busy  out  1: a partial word is in progress (bit count is non-zero).

## Operation
- Internal state: shift register sr[WIDTH-1:0], bit counter cnt (0..WIDTH, or 0..WIDTH+1 with parity), holding register, FSM.
- FSM states and transitions:
  - IDLE (cnt==0): an accepted bit moves to COLLECT.
  - COLLECT: the WIDTH-th accepted bit moves to IDLE. With parity, it moves to PARITY instead.
  - PARITY: the next accepted bit completes the word and moves to IDLE.
- Shift rules, per accepted bit:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
- Word completion, on the edge that accepts the final bit:
  - The completed value (including that bit) loads the holding register.
  - q_valid is set, cnt returns to 0, and sr is cleared.
- Completion while the holding register is full:
  - Not drained that cycle: the new word is dropped, the holding register keeps its old word, and overrun pulses for 1 cycle.
  - Drained the same cycle (q_ready=1): the new word loads, q_valid stays 1, and no overrun occurs.
- Handshake: q_data and q_perr are stable while q_valid=1 and q_ready=0. A drain with no completion clears q_valid.
- sin_valid=0 freezes sr and cnt. Gaps of any length are legal.
- Priority: rst_n, then clear, then normal operation.
  - clear zeroes sr, cnt, q_valid and overrun, and returns the FSM to IDLE.
  - A bit presented with clear is discarded.
- busy = (cnt != 0).

## Timing
- Reset values: q_data=0, q_valid=0, q_perr=0, overrun=0, busy=0, FSM=IDLE.
- Latency: q_valid rises at the edge that accepts the final bit (parity bit with the option), i.e. 0 cycles after that edge.
- Throughput: 1 word per WIDTH accepted bits (WIDTH+1 with parity).
- No combinational path from sin, sin_valid or q_ready to any output.
- Reset assertion mid-word discards the partial word immediately. After deassertion, the first accepted bit starts a new word.

## Configuration
- SIPO_PARITY_EN defined:
  - Each word is followed by one even-parity bit; the XOR of the WIDTH data bits and the parity bit must be 0.
  - The parity bit is not shifted into sr.
  - q_perr=1 with the word when the check fails. The word is still delivered.
- SIPO_PARITY_EN undefined: the PARITY state is not generated, words are WIDTH bits, and q_perr is tied to 0.

## Structure
- Package sipo_pkg holds:
  - the FSM state enum (IDLE, COLLECT, PARITY);
  - the counter width function, $clog2(WIDTH+2);
  - the even-parity function.
- Sub-module sipo_shift_core contains sr and its direction mux, parametrised by WIDTH and MSB_FIRST, with enable and clear inputs. The FSM, counter, holding register and handshake live in the top.

## Test plan
- Bit order: WIDTH=8, MSB_FIRST=1, q_ready=1, bits 1,1,0,0,0,0,0,1 on consecutive cycles → q_data=8'hC1, q_valid high 1 cycle. Same stream with MSB_FIRST=0 → 8'h83.
- Gaps and backpressure: same stream with sin_valid low on every other cycle → 8'hC1; busy is high from the first bit until completion. With q_ready=0, q_data holds 8'hC1 indefinitely.
- Overrun: q_ready=0, two full words 8'hC1 then 8'h3C → overrun pulses once and q_data stays 8'hC1. Repeat with q_ready=1 on the completion cycle → q_data=8'h3C and no overrun.
- Flush: rst_n low after 3 bits → all outputs 0. Separately, clear after 5 bits, then 8 new bits forming 8'hA5 → q_data=8'hA5.
- Parity (SIPO_PARITY_EN): 8'hC1 followed by parity bit 1 → q_perr=0. Followed by parity bit 0 → q_perr=1 and q_data=8'hC1.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StParity
    } sipo_state_e;

    // Upper bound on word width accepted by even_parity().
    localparam int unsigned MaxWidth = 256;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 2);
    endfunction

    function automatic logic even_parity(input logic [MaxWidth-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input and word output handshake of sipo_deserializer.
interface sipo_deserializer_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             sin_valid;
    logic             sin;
    logic [WIDTH-1:0] q_data;
    logic             q_valid;
    logic             q_ready;
    logic             q_perr;
    logic             overrun;
    logic             busy;

    modport master (
        output sin_valid, sin, q_ready,
        input  q_data, q_valid, q_perr, overrun, busy
    );

    modport slave (
        input  sin_valid, sin, q_ready,
        output q_data, q_valid, q_perr, overrun, busy
    );
endinterface

// File: rtl/sipo_shift_core.sv
// Shift register with elaboration-time bit order; clr has priority over en.
module sipo_shift_core #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] sr_o,
    output logic [WIDTH-1:0] shifted_o
);
    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        if (MSB_FIRST) begin
            shifted_o = {sr_q[WIDTH-2:0], sin_i};
        end else begin
            shifted_o = {sin_i, sr_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        sr_d = sr_q;
        if (clr_i) begin
            sr_d = '0;
        end else if (en_i) begin
            sr_d = shifted_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_o = sr_q;
endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with double-buffered valid/ready output.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per word.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    input logic                clear,
    sipo_deserializer_if.slave bus
);
    localparam int unsigned CntW = cnt_width(WIDTH);

    sipo_state_e      state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] sr, shifted, word;
    logic             accept, last_data, word_done, shift_en, drain;

    assign accept    = bus.sin_valid & ~clear;
    assign last_data = (state_q == StCollect) && (cnt_q == CntW'(WIDTH - 1));
    assign drain     = valid_q & bus.q_ready;

`ifdef SIPO_PARITY_EN
    logic perr_q, perr_d, perr_new;

    // Parity bit is checked against the held data, never shifted in.
    assign shift_en  = accept && (state_q != StParity);
    assign word_done = accept && (state_q == StParity);
    assign word      = sr;
    assign perr_new  = even_parity(MaxWidth'(sr)) ^ bus.sin;
`else
    logic unused_sr;

    assign unused_sr = ^sr;
    assign shift_en  = accept;
    assign word_done = accept && last_data;
    assign word      = shifted;
`endif

    sipo_shift_core #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shift_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (shift_en),
        .clr_i    (clear | word_done),
        .sin_i    (bus.sin),
        .sr_o     (sr),
        .shifted_o(shifted)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (accept) state_d = StCollect;
`ifdef SIPO_PARITY_EN
            StCollect: if (accept && last_data) state_d = StParity;
            StParity:  if (accept) state_d = StIdle;
`else
            StCollect: if (accept && last_data) state_d = StIdle;
`endif
            default:   state_d = StIdle;
        endcase
        if (clear) state_d = StIdle;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear || word_done) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_comb begin
        valid_d = valid_q;
        hold_d  = hold_q;
        ovr_d   = 1'b0;
`ifdef SIPO_PARITY_EN
        perr_d  = perr_q;
`endif
        if (clear) begin
            valid_d = 1'b0;
        end else begin
            if (drain) valid_d = 1'b0;
            // A full, undrained holding register drops the new word.
            if (word_done) begin
                if (!valid_q || drain) begin
                    valid_d = 1'b1;
                    hold_d  = word;
`ifdef SIPO_PARITY_EN
                    perr_d  = perr_new;
`endif
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bus.q_perr = perr_q;
`else
    assign bus.q_perr = 1'b0;
`endif

    assign bus.q_data  = hold_q;
    assign bus.q_valid = valid_q;
    assign bus.overrun = ovr_q;
    assign bus.busy    = (cnt_q != '0);
endmodule
